ifetch_ir: RTL and testbench
============================

# ifetch_ir

Instruction-fetch and instruction-register stage of the SLC-3 datapath. Holds PC, MAR, MDR and IR, and runs the fetch sequence against the synchronous on-board memory with a configurable read latency. Presents the decoded IR fields, including the raw imm5/offset6/PCoffset9/PCoffset11 fields, to the downstream sign-extension units and register file. The control FSM starts a fetch with a one-cycle request and waits for a one-cycle valid pulse.

## Interface
- MEM_WAIT, 2: memory read latency in cycles, legal 1..7
- PC_RESET, 16'h0000: PC value after reset
- Clk  in  1  system clock; all state updates on rising edge
- Reset  in  1  synchronous, active-low reset
- fetch_req  in  1  start fetch; sampled only in IDLE
- ld_pc  in  1  PC redirect strobe
- pc_in  in  16  redirect target
- mem_addr  out  16  memory address, equal to MAR
- mem_oe  out  1  memory read enable
- mem_rdata  in  16  memory read data, valid on the last WAIT cycle
- busy  out  1  high in any state other than IDLE
- ir_valid  out  1  one-cycle pulse when IR is updated
- pc  out  16  current PC
- ir  out  16  instruction register
- opcode  out  4  IR[15:12]
- dr  out  3  IR[11:9]
- sr1  out  3  IR[8:6]
- sr2  out  3  IR[2:0]
- imm5  out  5  IR[4:0], raw
- offset6  out  6  IR[5:0], raw
- pcoff9  out  9  IR[8:0], raw
- pcoff11  out  11  IR[10:0], raw
- halted  out  1  see Configuration

## Operation
- States: IDLE, WAIT, CAPTURE, LOAD_IR. One-hot or binary encoding is acceptable.
- IDLE with fetch_req=1:
  - MAR<=pc, pc<=pc+1 (mod 2^16, so FFFF wraps to 0000)
  - wait counter<=MEM_WAIT-1, go to WAIT
- WAIT:
  - mem_oe=1
  - When the counter is 0: MDR<=mem_rdata, go to CAPTURE; otherwise decrement.
- CAPTURE: go to LOAD_IR. Exists to match the memory output register.
- LOAD_IR: IR<=MDR, ir_valid<=1 for the next cycle, go to IDLE.
- ld_pc in IDLE:
  - pc<=pc_in.
  - With fetch_req in the same cycle: MAR<=pc_in and pc<=pc_in+1. The redirect applies before the fetch.
- ld_pc while busy:
  - Latch pc_in into a pending register and set pending.
  - On the cycle the FSM returns to IDLE: pc<=pending value, clear pending.
  - A later ld_pc while busy overwrites the pending value.
  - A fetch_req in that first IDLE cycle uses the pending value as the address.
- fetch_req outside IDLE is ignored. It is not queued.
- Field outputs are continuous slices of IR. Sign extension happens downstream.
- Reset (any state, including mid-fetch): state=IDLE, pc=PC_RESET, MAR=MDR=IR=0, pending=0, ir_valid=0, mem_oe=0, busy=0, halted=0. An in-flight read is abandoned and its data is never loaded.

## Timing
- fetch_req seen in cycle 0 → mem_oe high in cycles 1..MEM_WAIT → CAPTURE in cycle MEM_WAIT+1 → LOAD_IR in MEM_WAIT+2 → ir_valid and the new IR in cycle MEM_WAIT+3.
- Default MEM_WAIT=2: ir_valid in cycle 5, latency 5.
- busy is high from cycle 1 through cycle MEM_WAIT+2.
- Earliest next fetch_req acceptance is cycle MEM_WAIT+3, so back-to-back throughput is one instruction per MEM_WAIT+3 cycles.
- pc is updated at the end of cycle 0. ir changes only at the end of LOAD_IR.

## Configuration
- IFETCH_HALT_EN defined:
  - If LOAD_IR loads 16'hF025 (TRAP x25, HALT), halted<=1 together with ir_valid.
  - While halted, fetch_req is ignored.
  - ld_pc clears halted and performs the normal redirect. Reset also clears it.
- IFETCH_HALT_EN undefined: halted is tied to 0, with no halt logic or state.

## Test plan
- Basic fetch: reset, pc=0000, mem[0000]=16'h1261, fetch_req one cycle → ir_valid in cycle 5, ir=1261, opcode=1, dr=1, sr1=1, imm5=5'h01, pc=0001, mem_oe high exactly in cycles 1–2.
- Redirect plus fetch: in IDLE, ld_pc=1, pc_in=3000, and fetch_req together; mem[3000]=16'h0BFE → mem_addr=3000, pc=3001, pcoff9=9'h1FE, pcoff11=11'h3FE.
- Pending redirect and wrap: pc=FFFF, fetch_req, then ld_pc pc_in=1234 in cycle 2 → fetch uses address FFFF, pc reads 0000 during busy, then 1234 on return to IDLE. A fetch_req in that cycle reads address 1234.
- Reset mid-fetch: Reset=0 in cycle 2 of a fetch → next cycle busy=0, mem_oe=0, pc=PC_RESET, ir=0, and no ir_valid pulse for that fetch.
- MEM_WAIT=5 back-to-back: fetch_req held high continuously → ir_valid pulses every 8 cycles, first pulse in cycle 8.
- With IFETCH_HALT_EN: mem[0000]=F025, fetch → halted=1. Further fetch_req pulses produce no busy. ld_pc pc_in=0200 → halted=0, pc=0200.

Source files
------------

// File: rtl/ifetch_ir_if.sv
// SLC-3 fetch stage bundle: control strobes, memory port and decoded IR fields.
// master = fetch stage (drives memory address/enable and IR outputs), slave = surrounding datapath/memory.
interface ifetch_ir_if;
  logic        fetch_req;
  logic        ld_pc;
  logic [15:0] pc_in;
  logic [15:0] mem_addr;
  logic        mem_oe;
  logic [15:0] mem_rdata;
  logic        busy;
  logic        ir_valid;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [3:0]  opcode;
  logic [2:0]  dr;
  logic [2:0]  sr1;
  logic [2:0]  sr2;
  logic [4:0]  imm5;
  logic [5:0]  offset6;
  logic [8:0]  pcoff9;
  logic [10:0] pcoff11;
  logic        halted;

  modport master (
    input  fetch_req, ld_pc, pc_in, mem_rdata,
    output mem_addr, mem_oe, busy, ir_valid, pc, ir,
           opcode, dr, sr1, sr2, imm5, offset6, pcoff9, pcoff11, halted
  );

  modport slave (
    output fetch_req, ld_pc, pc_in, mem_rdata,
    input  mem_addr, mem_oe, busy, ir_valid, pc, ir,
           opcode, dr, sr1, sr2, imm5, offset6, pcoff9, pcoff11, halted
  );
endinterface

// File: rtl/ifetch_ir.sv
// SLC-3 fetch/IR stage: fetch_req -> ir_valid after MEM_WAIT+3 cycles; requests outside IDLE are dropped, not queued.
// Optional HALT detection (TRAP x25 stops fetching until ld_pc) is built only with IFETCH_HALT_EN defined.
module ifetch_ir #(
  parameter int          MEM_WAIT = 2,
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input logic           Clk,
  input logic           Reset,
  ifetch_ir_if.master   bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_LOAD_IR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] pend_q, pend_d;
  logic        pend_vld_q, pend_vld_d;
  logic        ir_valid_q, ir_valid_d;
  logic        mem_oe;
  logic        fetch_ok;
  logic [15:0] pc_eff;

`ifdef IFETCH_HALT_EN
  logic        halted_q, halted_d;
  assign fetch_ok   = bus.fetch_req & ~halted_q;
  assign bus.halted = halted_q;
`else
  assign fetch_ok   = bus.fetch_req;
  assign bus.halted = 1'b0;
`endif

  // A same-cycle redirect takes effect before the fetch address is chosen.
  assign pc_eff = bus.ld_pc ? bus.pc_in : pc_q;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= 3'd0;
      pc_q       <= PC_RESET;
      mar_q      <= 16'h0000;
      mdr_q      <= 16'h0000;
      ir_q       <= 16'h0000;
      pend_q     <= 16'h0000;
      pend_vld_q <= 1'b0;
      ir_valid_q <= 1'b0;
`ifdef IFETCH_HALT_EN
      halted_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ir_valid_q <= ir_valid_d;
`ifdef IFETCH_HALT_EN
      halted_q   <= halted_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_d       = pc_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    ir_d       = ir_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ir_valid_d = 1'b0;
    mem_oe     = 1'b0;
`ifdef IFETCH_HALT_EN
    halted_d   = halted_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.ld_pc) begin
          pc_d = bus.pc_in;
`ifdef IFETCH_HALT_EN
          halted_d = 1'b0;
`endif
        end
        if (fetch_ok) begin
          mar_d   = pc_eff;
          pc_d    = pc_eff + 16'd1;
          cnt_d   = 3'(MEM_WAIT - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        mem_oe = 1'b1;
        if (cnt_q == 3'd0) begin
          mdr_d   = bus.mem_rdata;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
        if (bus.ld_pc) begin
          pend_d     = bus.pc_in;
          pend_vld_d = 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_LOAD_IR;
        if (bus.ld_pc) begin
          pend_d     = bus.pc_in;
          pend_vld_d = 1'b1;
        end
      end
      default: begin
        // LOAD_IR: a redirect arriving now or parked earlier lands as we return to IDLE.
        ir_d       = mdr_q;
        ir_valid_d = 1'b1;
        state_d    = S_IDLE;
        if (bus.ld_pc) begin
          pc_d = bus.pc_in;
        end else if (pend_vld_q) begin
          pc_d = pend_q;
        end
        pend_vld_d = 1'b0;
`ifdef IFETCH_HALT_EN
        if (mdr_q == 16'hF025) halted_d = 1'b1;
`endif
      end
    endcase
  end

  assign bus.mem_addr = mar_q;
  assign bus.mem_oe   = mem_oe;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.ir_valid = ir_valid_q;
  assign bus.pc       = pc_q;
  assign bus.ir       = ir_q;
  assign bus.opcode   = ir_q[15:12];
  assign bus.dr       = ir_q[11:9];
  assign bus.sr1      = ir_q[8:6];
  assign bus.sr2      = ir_q[2:0];
  assign bus.imm5     = ir_q[4:0];
  assign bus.offset6  = ir_q[5:0];
  assign bus.pcoff9   = ir_q[8:0];
  assign bus.pcoff11  = ir_q[10:0];

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: one instance at MEM_WAIT=2 with a small memory table, one at MEM_WAIT=5 for throughput.
module tb_ifetch_ir;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  logic [15:0] mem_a [4];
  logic [15:0] mem_d [4];

  ifetch_ir_if bus2();
  ifetch_ir_if bus5();

  ifetch_ir #(.MEM_WAIT(2), .PC_RESET(16'h0000)) dut2 (.Clk(clk), .Reset(rst_n), .bus(bus2));
  ifetch_ir #(.MEM_WAIT(5), .PC_RESET(16'h0000)) dut5 (.Clk(clk), .Reset(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    bus2.mem_rdata = 16'hDEAD;
    for (int i = 0; i < 4; i++)
      if (mem_a[i] == bus2.mem_addr) bus2.mem_rdata = mem_d[i];
  end
  assign bus5.mem_rdata = 16'hA5A5;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs then show the new cycle's state.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic saw_vld;
    n_chk = 0;
    n_fail = 0;
    mem_a[0] = 16'h0000; mem_d[0] = 16'h1261;
    mem_a[1] = 16'h3000; mem_d[1] = 16'h0BFE;
    mem_a[2] = 16'hFFFF; mem_d[2] = 16'h7ABC;
    mem_a[3] = 16'h1234; mem_d[3] = 16'h5E2A;
    rst_n = 1'b0;
    bus2.fetch_req = 1'b0; bus2.ld_pc = 1'b0; bus2.pc_in = 16'h0000;
    bus5.fetch_req = 1'b0; bus5.ld_pc = 1'b0; bus5.pc_in = 16'h0000;
    step(2);

    chk("rst_pc", bus2.pc, 16'h0000);
    chk("rst_ir", bus2.ir, 16'h0000);
    chk("rst_busy", bus2.busy, 1'b0);
    chk("rst_oe", bus2.mem_oe, 1'b0);
    chk("rst_vld", bus2.ir_valid, 1'b0);
    chk("rst_addr", bus2.mem_addr, 16'h0000);
    chk("rst_halted", bus2.halted, 1'b0);
    rst_n = 1'b1;
    step();

    // Basic fetch from 0000.
    bus2.fetch_req = 1'b1;
    step(); bus2.fetch_req = 1'b0;
    chk("f1_c1_oe", bus2.mem_oe, 1'b1);
    chk("f1_c1_busy", bus2.busy, 1'b1);
    chk("f1_c1_pc", bus2.pc, 16'h0001);
    chk("f1_c1_addr", bus2.mem_addr, 16'h0000);
    step(); chk("f1_c2_oe", bus2.mem_oe, 1'b1);
    step(); chk("f1_c3_oe", bus2.mem_oe, 1'b0);
    chk("f1_c3_busy", bus2.busy, 1'b1);
    step(); chk("f1_c4_vld", bus2.ir_valid, 1'b0);
    chk("f1_c4_busy", bus2.busy, 1'b1);
    chk("f1_c4_ir", bus2.ir, 16'h0000);
    step(); chk("f1_c5_vld", bus2.ir_valid, 1'b1);
    chk("f1_ir", bus2.ir, 16'h1261);
    chk("f1_opcode", bus2.opcode, 4'h1);
    chk("f1_dr", bus2.dr, 3'd1);
    chk("f1_sr1", bus2.sr1, 3'd1);
    chk("f1_sr2", bus2.sr2, 3'd1);
    chk("f1_imm5", bus2.imm5, 5'h01);
    chk("f1_off6", bus2.offset6, 6'h21);
    chk("f1_c5_busy", bus2.busy, 1'b0);
    chk("f1_c5_pc", bus2.pc, 16'h0001);

    // Redirect and fetch in the same IDLE cycle.
    bus2.ld_pc = 1'b1; bus2.pc_in = 16'h3000; bus2.fetch_req = 1'b1;
    step(); bus2.ld_pc = 1'b0; bus2.fetch_req = 1'b0;
    chk("f1_c6_vld", bus2.ir_valid, 1'b0);
    chk("f2_addr", bus2.mem_addr, 16'h3000);
    chk("f2_pc", bus2.pc, 16'h3001);
    step(4);
    chk("f2_vld", bus2.ir_valid, 1'b1);
    chk("f2_ir", bus2.ir, 16'h0BFE);
    chk("f2_opcode", bus2.opcode, 4'h0);
    chk("f2_dr", bus2.dr, 3'd5);
    chk("f2_pcoff9", bus2.pcoff9, 9'h1FE);
    chk("f2_pcoff11", bus2.pcoff11, 11'h3FE);

    // Fetch at FFFF with a redirect parked mid-fetch.
    bus2.ld_pc = 1'b1; bus2.pc_in = 16'hFFFF;
    step(); bus2.ld_pc = 1'b0;
    chk("f3_pc_ffff", bus2.pc, 16'hFFFF);
    chk("f3_idle", bus2.busy, 1'b0);
    bus2.fetch_req = 1'b1;
    step(); bus2.fetch_req = 1'b0;
    chk("f3_addr", bus2.mem_addr, 16'hFFFF);
    chk("f3_wrap", bus2.pc, 16'h0000);
    step();
    bus2.ld_pc = 1'b1; bus2.pc_in = 16'h1234;
    step(); bus2.ld_pc = 1'b0;
    chk("f3_c3_pc", bus2.pc, 16'h0000);
    chk("f3_c3_busy", bus2.busy, 1'b1);
    step(); chk("f3_c4_pc", bus2.pc, 16'h0000);
    step(); chk("f3_vld", bus2.ir_valid, 1'b1);
    chk("f3_ir", bus2.ir, 16'h7ABC);
    chk("f3_pend_pc", bus2.pc, 16'h1234);
    bus2.fetch_req = 1'b1;
    step(); bus2.fetch_req = 1'b0;
    chk("f3b_addr", bus2.mem_addr, 16'h1234);
    chk("f3b_pc", bus2.pc, 16'h1235);
    step(4);
    chk("f3b_vld", bus2.ir_valid, 1'b1);
    chk("f3b_ir", bus2.ir, 16'h5E2A);

    // Reset in cycle 2 of a fetch.
    bus2.fetch_req = 1'b1;
    step(); bus2.fetch_req = 1'b0;
    step(); rst_n = 1'b0;
    step(); rst_n = 1'b1;
    chk("r_busy", bus2.busy, 1'b0);
    chk("r_oe", bus2.mem_oe, 1'b0);
    chk("r_pc", bus2.pc, 16'h0000);
    chk("r_ir", bus2.ir, 16'h0000);
    chk("r_addr", bus2.mem_addr, 16'h0000);
    saw_vld = 1'b0;
    for (int c = 0; c < 6; c++) begin
      saw_vld = saw_vld | bus2.ir_valid;
      step();
    end
    chk("r_no_vld", saw_vld, 1'b0);

    // MEM_WAIT=5 with fetch_req held: a pulse every 8 cycles.
    bus5.fetch_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      step();
      chk($sformatf("w5_vld_c%0d", c), bus5.ir_valid, (c % 8 == 0) ? 1'b1 : 1'b0);
      if (c == 8) chk("w5_ir", bus5.ir, 16'hA5A5);
      if (c == 3) chk("w5_busy", bus5.busy, 1'b1);
    end
    bus5.fetch_req = 1'b0;

`ifdef IFETCH_HALT_EN
    mem_d[0] = 16'hF025;
    bus2.fetch_req = 1'b1;
    step(); bus2.fetch_req = 1'b0;
    step(4);
    chk("h_vld", bus2.ir_valid, 1'b1);
    chk("h_ir", bus2.ir, 16'hF025);
    chk("h_halted", bus2.halted, 1'b1);
    bus2.fetch_req = 1'b1;
    step(); chk("h_nobusy1", bus2.busy, 1'b0);
    step(); chk("h_nobusy2", bus2.busy, 1'b0);
    bus2.fetch_req = 1'b0;
    bus2.ld_pc = 1'b1; bus2.pc_in = 16'h0200;
    step(); bus2.ld_pc = 1'b0;
    chk("h_cleared", bus2.halted, 1'b0);
    chk("h_pc", bus2.pc, 16'h0200);
`else
    chk("nohalt_tied", bus2.halted, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
